// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle for the immediate generator: upstream immediate/mode,
// flush, downstream result and status flags.
interface imm_ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  inp;
  logic [2:0]       mode;
  logic             flush;
  logic [OUT_W-1:0] res;
  logic             out_valid;
  logic             out_ready;
  logic             prefix_pending;
  logic             err;

  modport master (
    output in_valid, inp, mode, flush, out_ready,
    input  in_ready, res, out_valid, prefix_pending, err
  );

  modport slave (
    input  in_valid, inp, mode, flush, out_ready,
    output in_ready, res, out_valid, prefix_pending, err
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// Registered immediate generator. One-cycle latency, valid/ready on both
// sides; a PREFIX beat supplies the upper IN_W bits of the next immediate.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  imm_ext_pipe_if.slave  bus
);
  generate
    if (OUT_W < 2*IN_W) begin : g_bad_width
      $error("imm_ext_pipe: OUT_W must be >= 2*IN_W");
    end
  endgenerate

  localparam logic [2:0] M_ZERO   = 3'd0;
  localparam logic [2:0] M_SIGN   = 3'd1;
  localparam logic [2:0] M_UPPER  = 3'd2;
  localparam logic [2:0] M_BRANCH = 3'd3;
  localparam logic [2:0] M_PREFIX = 3'd4;

  typedef enum logic {IDLE, PREFIXED} state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   pfx_q, pfx_d;
  logic [OUT_W-1:0]  res_q, res_d;
  logic              ov_q, ov_d;
  logic              err_q, err_d;
  logic              in_ready;
  logic              acc;
  logic [2*IN_W-1:0] x_wide;
  logic [OUT_W-1:0]  zx, sx, ext;

  // Ready only depends on whether the output slot frees up this cycle.
  assign in_ready           = !ov_q || bus.out_ready;
  assign acc                = bus.in_valid && in_ready;
  assign bus.in_ready       = in_ready;
  assign bus.res            = res_q;
  assign bus.out_valid      = ov_q;
  assign bus.err            = err_q;
  assign bus.prefix_pending = (state_q == PREFIXED);
  assign x_wide             = {pfx_q, bus.inp};

  // Operand extension: narrow field alone, or prefix:field when a prefix waits.
  always_comb begin
    zx = OUT_W'(bus.inp);
    sx = OUT_W'($signed(bus.inp));
    if (state_q == PREFIXED) begin
      zx = OUT_W'(x_wide);
      sx = OUT_W'($signed(x_wide));
    end
    case (bus.mode)
      M_SIGN:   ext = sx;
      M_UPPER:  ext = zx << IN_W;
      M_BRANCH: ext = sx << 2;
      default:  ext = zx;  // ZERO and reserved encodings
    endcase
  end

  // Next-state: prefix FSM, output slot, error pulse; flush overrides all.
  always_comb begin
    state_d = state_q;
    pfx_d   = pfx_q;
    res_d   = res_q;
    ov_d    = ov_q && !bus.out_ready;
    err_d   = 1'b0;
    if (acc) begin
      if (bus.mode == M_PREFIX) begin
        pfx_d   = bus.inp;
        err_d   = (state_q == PREFIXED);  // second prefix: last one wins
        state_d = PREFIXED;
      end else begin
        res_d   = ext;
        ov_d    = 1'b1;
        err_d   = (bus.mode > M_PREFIX);
        state_d = IDLE;
      end
    end
    if (bus.flush) begin
      state_d = IDLE;
      pfx_d   = '0;
      res_d   = res_q;
      ov_d    = 1'b0;
      err_d   = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pfx_q   <= '0;
      res_q   <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pfx_q   <= pfx_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Registered, parametrised immediate generator for the decode stage. Takes an IN_W-bit instruction immediate with a mode select and produces an OUT_W-bit operand one cycle later over a valid/ready handshake.
- Supports zero-extend, sign-extend, upper-load and branch-offset modes.
- A prefix instruction supplies the upper IN_W bits of the next immediate. This allows immediates wider than one instruction field.

Parameters:
- IN_W, 16, immediate field width.
- OUT_W, 32, result width. Must be >= 2*IN_W (elaboration-time check).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream immediate valid.
- in_ready  output  1  block can accept this cycle.
- inp  input  IN_W  immediate field.
- mode  input  3  0 ZERO, 1 SIGN, 2 UPPER, 3 BRANCH, 4 PREFIX, 5-7 reserved.
- flush  input  1  pipeline flush; discards pending prefix and output.
- res  output  OUT_W  generated immediate.
- out_valid  output  1  res valid.
- out_ready  input  1  downstream accepts res.
- prefix_pending  output  1  a prefix is latched and awaiting its consumer.
- err  output  1  one-cycle pulse on protocol or mode error.

Behaviour:
- Reset (rst_n low, asynchronous) forces the following, regardless of clk:
  - res=0, out_valid=0, err=0.
  - Prefix register=0; state=IDLE, so prefix_pending=0.
- Handshake:
  - in_ready = !out_valid || out_ready. It is combinational and independent of in_valid.
  - Accept occurs when in_valid && in_ready.
  - res/out_valid update on the clk edge after accept; latency 1 cycle.
  - res is held stable while out_valid && !out_ready.
  - Output is consumed when out_valid && out_ready. With no new non-prefix accept in that cycle, out_valid falls next edge.
  - Simultaneous consume plus accept gives back-to-back throughput of 1 per cycle.
- State machine, two states:
  - IDLE: accepting PREFIX stores inp into the prefix register and moves to PREFIXED; out_valid is not set.
  - IDLE: accepting any other mode produces output using X = inp (IN_W bits).
  - PREFIXED: accepting a non-prefix mode produces output using X = {prefix, inp} (2*IN_W bits) and returns to IDLE.
  - PREFIXED: accepting PREFIX overwrites the prefix (last wins), stays PREFIXED and pulses err.
  - prefix_pending = (state == PREFIXED).
- Arithmetic, with W = width of X:
  - ZERO: res = zero-extend X to OUT_W.
  - SIGN: res = sign-extend X from bit W-1 to OUT_W.
  - UPPER: res = (zero-extend X) << IN_W, truncated to OUT_W.
  - BRANCH: res = (sign-extend X) << 2, truncated to OUT_W; bits lost off the top are discarded silently.
  - Reserved modes 5-7: treated as ZERO, output produced, err pulsed in the accept cycle (registered, visible next edge).
- Flush:
  - Synchronous; highest priority.
  - Next edge: out_valid=0, state=IDLE, prefix cleared. Any input accepted in the same cycle is discarded.
  - res keeps its last value (don't-care while out_valid=0).
  - in_ready is unaffected by flush.
- err timing: err is registered, high exactly one cycle after the offending accept, and cleared by flush/reset.
- No accept while in_valid=0: state, prefix and res are unchanged.
- Reset mid-operation (e.g. PREFIXED with out_valid high) returns to reset values immediately; no output is produced for the pending prefix.

Test Plan:
- Reset/basic (defaults):
  - Assert rst_n=0 mid-cycle -> out_valid=0, res=0, prefix_pending=0 without a clock edge.
  - Release, send inp=16'h8001 mode SIGN -> next cycle res=32'hFFFF8001, out_valid=1.
- Modes without prefix:
  - inp=16'h8001 ZERO -> 32'h00008001.
  - UPPER -> 32'h80010000.
  - BRANCH -> 32'hFFFE0004.
  - mode 6 -> 32'h00008001 with err=1 for one cycle.
- Prefix path:
  - PREFIX inp=16'h1234 -> no out_valid, prefix_pending=1.
  - Then SIGN inp=16'hABCD -> res=32'h1234ABCD, prefix_pending=0.
  - PREFIX 16'hFFFF then BRANCH 16'hFFFE -> res=32'hFFFFFFF8.
- Double prefix:
  - PREFIX 16'h1111, PREFIX 16'h2222 (err pulses), ZERO 16'h0001 -> res=32'h22220001.
- Backpressure:
  - out_ready=0 with out_valid=1 -> in_ready=0, res held for 5 cycles despite changing inp/in_valid.
  - Raise out_ready with a new accept -> new result next cycle, no bubble, no lost or duplicated item.
- Flush:
  - In PREFIXED with out_valid=1, assert flush alongside an accept of ZERO 16'h0005 -> next cycle out_valid=0, prefix_pending=0.
  - Following ZERO 16'h0005 -> res=32'h00000005 (no prefix applied).
